dispatch4way_ctrl: RTL

- Registered, flow-controlled 1-to-4 dispatcher built around the 4-way demux function.
- Steers each accepted input word to one of four output channels (0=a, 1=b, 2=c, 3=d), selected either by an explicit select field or by a round-robin pointer.
- Each channel has a one-entry holding slot with valid/ready handshake and a delivered-word counter.
- Sits between a word producer, such as the CPU memory/IO path, and up to four consumers.

---
 rtl/dispatch4way_ctrl.sv | 73 +++++++
 1 files changed

// File: rtl/dispatch4way_ctrl.sv
// 1-to-4 registered dispatcher with a one-entry slot per channel, 1-cycle accept-to-valid latency.
// in_ready drops only when the target slot is full and its consumer is not draining it this cycle.
module dispatch4way_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               rr_mode,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [1:0]         rr_ptr,
  output logic [4*CNT_W-1:0] cnt
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t      state      [4];
  slot_state_t      state_next [4];
  logic [WIDTH-1:0] slot_dat   [4];
  logic [CNT_W-1:0] cnt_q      [4];
  logic [1:0]       target;
  logic             accept;
  logic [3:0]       load;
  logic [3:0]       drain;

  assign target   = rr_mode ? rr_ptr : in_sel;
  // A full target still accepts when its consumer drains in the same cycle.
  assign in_ready = !reset && ((state[target] == EMPTY) || out_ready[target]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    load  = '0;
    drain = '0;
    for (int i = 0; i < 4; i++) begin
      state_next[i] = state[i];
      load[i]       = accept && (target == 2'(i));
      drain[i]      = (state[i] == FULL) && out_ready[i];
      case (state[i])
        EMPTY: if (load[i]) state_next[i] = FULL;
        FULL:  if (drain[i] && !load[i]) state_next[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i]    <= EMPTY;
        slot_dat[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      if (accept && rr_mode) rr_ptr <= rr_ptr + 2'd1;
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_next[i];
        if (load[i])  slot_dat[i] <= in_data;
        if (drain[i]) cnt_q[i]    <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    assign out_valid[g]               = (state[g] == FULL);
    assign out_data[g*WIDTH +: WIDTH] = (state[g] == FULL) ? slot_dat[g] : '0;
    assign cnt[g*CNT_W +: CNT_W]      = cnt_q[g];
  end
endmodule
